// File: rtl/iq_issue_scheduler.sv
// Dual-slot read scheduler for the IR-stage instruction queue: picks 0/1/2 head
// pops per cycle, sequences post-flush hold-off and CSR serialization, counts stalls.
module iq_issue_scheduler #(
  parameter int NUM_ENTRIES       = 8,
  parameter int FLUSH_HOLD_CYCLES = 2,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [$clog2(NUM_ENTRIES):0]   iq_num_i,
  input  logic [1:0]                     head0_class_i,
  input  logic [1:0]                     head1_class_i,
  input  logic                           rr_ready_i,
  input  logic                           mem_port_busy_i,
  input  logic                           pipeline_empty_i,
  input  logic                           dual_en_i,
  output logic [1:0]                     read_head_o,
  output logic [1:0]                     issue_count_o,
  output logic [1:0]                     state_o,
  output logic [STALL_CNT_W-1:0]         stall_cnt_o
);

  // state        | meaning
  // RUN          | normal issue, up to two pops per cycle
  // HOLD         | post-flush hold-off, hold_cnt counts down to 1
  // SERIAL_WAIT  | CSR at head: wait for drain (before and after its pop)
  // SERIAL_ISSUE | CSR pops alone
  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_HOLD         = 2'd1,
    ST_SERIAL_WAIT  = 2'd2,
    ST_SERIAL_ISSUE = 2'd3
  } state_t;

  localparam int          IQW      = $clog2(NUM_ENTRIES) + 1;
  localparam logic [1:0]  CLS_MEM  = 2'd1;
  localparam logic [1:0]  CLS_CTRL = 2'd2;
  localparam logic [1:0]  CLS_CSR  = 2'd3;
  localparam logic [3:0]  HOLD_LD  = 4'(FLUSH_HOLD_CYCLES);

  state_t                 state;
  logic [3:0]             hold_cnt;
  logic                   csr_issued;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic has_one, has_two, head0_csr;
  logic slot0_ok, slot1_ok, stall_cyc;

  assign has_one   = (iq_num_i >= IQW'(1));
  assign has_two   = (iq_num_i >= IQW'(2));
  assign head0_csr = (head0_class_i == CLS_CSR);

  always_comb begin
    slot0_ok = rr_ready_i && has_one && !head0_csr &&
               !((head0_class_i == CLS_MEM) && mem_port_busy_i);
    slot1_ok = slot0_ok && dual_en_i && has_two &&
               (head1_class_i != CLS_CSR) &&
               !((head0_class_i == CLS_MEM)  && (head1_class_i == CLS_MEM)) &&
               !((head0_class_i == CLS_CTRL) && (head1_class_i == CLS_CTRL)) &&
               !((head1_class_i == CLS_MEM)  && mem_port_busy_i);
    read_head_o = 2'b00;
    // Reset and flush both squash any pop, including a pending CSR issue.
    if (!rst_i && !flush_i) begin
      case (state)
        ST_RUN:          read_head_o = {slot1_ok, slot0_ok};
        ST_SERIAL_ISSUE: read_head_o = 2'b01;
        default:         read_head_o = 2'b00;
      endcase
    end
  end

  assign issue_count_o = {1'b0, read_head_o[0]} + {1'b0, read_head_o[1]};

  assign stall_cyc = ((state == ST_RUN) || (state == ST_SERIAL_WAIT)) &&
                     has_one && (read_head_o == 2'b00) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_RUN;
      hold_cnt   <= 4'd0;
      csr_issued <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (stall_cyc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush_i) begin
        state      <= ST_HOLD;
        hold_cnt   <= HOLD_LD;
        csr_issued <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (has_one && head0_csr)
              state <= ST_SERIAL_WAIT;
          end
          ST_HOLD: begin
            hold_cnt <= hold_cnt - 4'd1;
            if (hold_cnt == 4'd1) begin
              state      <= ST_RUN;
              csr_issued <= 1'b0;
            end
          end
          ST_SERIAL_WAIT: begin
            // First visit waits to issue the CSR; second visit waits for it to drain.
            if (!csr_issued) begin
              if (pipeline_empty_i && rr_ready_i)
                state <= ST_SERIAL_ISSUE;
            end else if (pipeline_empty_i) begin
              state      <= ST_RUN;
              csr_issued <= 1'b0;
            end
          end
          ST_SERIAL_ISSUE: begin
            state      <= ST_SERIAL_WAIT;
            csr_issued <= 1'b1;
          end
          default: begin
            state      <= ST_RUN;
            csr_issued <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Bench for iq_issue_scheduler: directed scenarios plus random stimulus, all
// checked every cycle against a rule-level reference model.
module tb_iq_issue_scheduler;

  localparam int FHC   = 2;
  localparam int SCW   = 4;
  localparam int SMAX  = (1 << SCW) - 1;
  localparam int ALU = 0, MEM = 1, CTRL = 2, CSR = 3;
  localparam int M_RUN = 0, M_HOLD = 1, M_SWAIT = 2, M_SISSUE = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_i, flush_i;
  logic [3:0]     iq_num_i;
  logic [1:0]     head0_class_i, head1_class_i;
  logic           rr_ready_i, mem_port_busy_i, pipeline_empty_i, dual_en_i;
  logic [1:0]     read_head_o, issue_count_o, state_o;
  logic [SCW-1:0] stall_cnt_o;

  iq_issue_scheduler #(
    .NUM_ENTRIES(8), .FLUSH_HOLD_CYCLES(FHC), .STALL_CNT_W(SCW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .iq_num_i(iq_num_i),
    .head0_class_i(head0_class_i), .head1_class_i(head1_class_i),
    .rr_ready_i(rr_ready_i), .mem_port_busy_i(mem_port_busy_i),
    .pipeline_empty_i(pipeline_empty_i), .dual_en_i(dual_en_i),
    .read_head_o(read_head_o), .issue_count_o(issue_count_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode, cycles of hold remaining, CSR already sent, stall count.
  int m_mode, m_hold_left, m_stall;
  bit m_csr_sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int model_pops();
    bit p0, p1;
    int n;
    if (rst_i || flush_i) return 0;
    if (m_mode == M_SISSUE) return 1;
    if (m_mode != M_RUN) return 0;
    n  = int'(iq_num_i);
    p0 = rr_ready_i && n >= 1 && head0_class_i != CSR &&
         !(head0_class_i == MEM && mem_port_busy_i);
    p1 = p0 && dual_en_i && n >= 2 && head1_class_i != CSR &&
         !(head0_class_i == MEM && head1_class_i == MEM) &&
         !(head0_class_i == CTRL && head1_class_i == CTRL) &&
         !(head1_class_i == MEM && mem_port_busy_i);
    return int'(p0) + int'(p1);
  endfunction

  task automatic model_step(input int pops);
    if (rst_i) begin
      m_mode = M_RUN; m_hold_left = 0; m_csr_sent = 0; m_stall = 0;
      return;
    end
    if ((m_mode == M_RUN || m_mode == M_SWAIT) && iq_num_i >= 1 && pops == 0 &&
        !flush_i && m_stall < SMAX)
      m_stall++;
    if (flush_i) begin
      m_mode = M_HOLD; m_hold_left = FHC; m_csr_sent = 0;
      return;
    end
    case (m_mode)
      M_RUN:   if (iq_num_i >= 1 && head0_class_i == CSR) m_mode = M_SWAIT;
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_mode = M_RUN;
      end
      M_SWAIT: begin
        if (!m_csr_sent) begin
          if (pipeline_empty_i && rr_ready_i) m_mode = M_SISSUE;
        end else if (pipeline_empty_i) begin
          m_mode = M_RUN; m_csr_sent = 0;
        end
      end
      default: begin m_mode = M_SWAIT; m_csr_sent = 1; end
    endcase
  endtask

  task automatic tick();
    int pops;
    pops = model_pops();
    @(negedge clk_i);
    check("read_head",   32'(read_head_o),   (pops == 2) ? 32'd3 : 32'(pops));
    check("issue_count", 32'(issue_count_o), 32'(pops));
    check("state",       32'(state_o),       32'(m_mode));
    check("stall_cnt",   32'(stall_cnt_o),   32'(m_stall));
    @(posedge clk_i);
    model_step(pops);
    #1;
  endtask

  task automatic drive(input bit rst, input bit fl, input int num, input int h0, input int h1,
                       input bit rr, input bit busy, input bit pe, input bit dual, input int n);
    rst_i = rst; flush_i = fl; iq_num_i = 4'(num);
    head0_class_i = 2'(h0); head1_class_i = 2'(h1);
    rr_ready_i = rr; mem_port_busy_i = busy; pipeline_empty_i = pe; dual_en_i = dual;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    drive(1, 0, 0, ALU, ALU, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    m_mode = M_RUN; m_hold_left = 0; m_csr_sent = 0; m_stall = 0;
    drive(1, 0, 4, ALU, ALU, 1, 0, 0, 1, 2);     // outputs forced low in reset
    // dual ALU issue, then structural conflicts
    drive(0, 0, 4, ALU,  ALU,  1, 0, 0, 1, 4);
    drive(0, 0, 4, MEM,  MEM,  1, 0, 0, 1, 3);
    drive(0, 0, 4, MEM,  MEM,  1, 1, 0, 1, 3);
    drive(0, 0, 4, ALU,  MEM,  1, 1, 0, 1, 2);
    drive(0, 0, 4, CTRL, CTRL, 1, 0, 0, 1, 2);
    drive(0, 0, 0, ALU,  ALU,  1, 0, 0, 1, 2);
    // flush hold-off and re-flush during hold
    drive(0, 1, 3, ALU, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 3, ALU, ALU, 1, 0, 0, 1, 3);
    drive(0, 1, 3, ALU, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 3, ALU, ALU, 1, 0, 0, 1, 1);
    drive(0, 1, 3, ALU, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 3, ALU, ALU, 1, 0, 0, 1, 4);
    // CSR serialization
    drive(1, 0, 3, CSR, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 3, CSR, ALU, 1, 0, 0, 1, 6);
    drive(0, 0, 3, CSR, ALU, 1, 0, 1, 1, 1);
    drive(0, 0, 2, ALU, ALU, 1, 0, 0, 1, 3);
    drive(0, 0, 2, ALU, ALU, 1, 0, 1, 1, 3);
    // flush cancels the CSR pop
    drive(0, 0, 3, CSR, ALU, 1, 0, 1, 1, 2);
    drive(0, 1, 3, CSR, ALU, 1, 0, 1, 1, 1);
    drive(0, 0, 3, ALU, ALU, 1, 0, 1, 1, 4);
    // single entry with a stale CSR behind it; single-issue config
    drive(0, 0, 1, ALU, CSR, 1, 0, 0, 1, 3);
    drive(0, 0, 5, ALU, ALU, 1, 0, 0, 0, 3);
    // stall counter saturation, then reset mid-SERIAL_WAIT and mid-HOLD
    drive(0, 0, 2, MEM, ALU, 1, 1, 0, 1, 20);
    drive(0, 0, 2, CSR, ALU, 1, 0, 0, 1, 3);
    drive(1, 0, 2, CSR, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 2, ALU, ALU, 1, 0, 0, 1, 2);
    drive(0, 1, 2, ALU, ALU, 1, 0, 0, 1, 1);
    drive(1, 0, 2, ALU, ALU, 1, 0, 0, 1, 1);
    drive(0, 0, 2, ALU, ALU, 1, 0, 0, 1, 2);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 64) == 0, ($urandom % 16) == 0, int'($urandom_range(0, 8)),
            int'($urandom % 4), int'($urandom % 4), ($urandom % 4) != 0,
            ($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 4) != 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
